// File: rtl/hazard_if.sv
// Pipeline hazard bus: ID/EX/DM status into the hazard controller, stall/flush/halt controls out.
interface hazard_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_rs_used;
   logic        id_rt_used;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rd;
   logic        ex_branch_taken;
   logic        dm_ready;
   logic        halt_req;
   logic        pc_we;
   logic        pc_src_branch;
   logic        if_id_we;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        pipe_freeze;
   logic        halt_ack;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output id_rs, id_rt, id_rs_used, id_rt_used, id_ex_mem_read, id_ex_rd,
             ex_branch_taken, dm_ready, halt_req,
      input  pc_we, pc_src_branch, if_id_we, if_id_flush, id_ex_flush,
             pipe_freeze, halt_ack, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_rs_used, id_rt_used, id_ex_mem_read, id_ex_rd,
             ex_branch_taken, dm_ready, halt_req,
      output pc_we, pc_src_branch, if_id_we, if_id_flush, id_ex_flush,
             pipe_freeze, halt_ack, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush, memory freeze, drain-and-halt.
module hazard_ctrl #(
   parameter int DRAIN_CYCLES = 4
) (
   input  logic     clk,
   input  logic     reset,
   hazard_if.slave  bus
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] drain_cnt, drain_cnt_nxt;
   logic [15:0]   stall_cnt_q, flush_cnt_q;
   logic          stall_inc, flush_inc;
   logic          load_use;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
                     ((bus.id_rs_used && (bus.id_rs == bus.id_ex_rd)) ||
                      (bus.id_rt_used && (bus.id_rt == bus.id_ex_rd)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         drain_cnt   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (flush_inc) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   always_comb begin
      state_nxt         = state;
      drain_cnt_nxt     = drain_cnt;
      stall_inc         = 1'b0;
      flush_inc         = 1'b0;
      bus.pc_we         = 1'b1;
      bus.pc_src_branch = 1'b0;
      bus.if_id_we      = 1'b1;
      bus.if_id_flush   = 1'b0;
      bus.id_ex_flush   = 1'b0;
      bus.pipe_freeze   = 1'b0;
      bus.halt_ack      = (state == HALTED);

      // A memory wait freezes everything, including the FSM and counters.
      if (!bus.dm_ready) begin
         bus.pc_we       = 1'b0;
         bus.if_id_we    = 1'b0;
         bus.pipe_freeze = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (bus.ex_branch_taken) begin
                  bus.pc_src_branch = 1'b1;
                  bus.if_id_flush   = 1'b1;
                  bus.id_ex_flush   = 1'b1;
                  flush_inc         = 1'b1;
               end else if (load_use) begin
                  bus.pc_we       = 1'b0;
                  bus.if_id_we    = 1'b0;
                  bus.id_ex_flush = 1'b1;
                  stall_inc       = 1'b1;
                  state_nxt       = STALL;
               end else if (bus.halt_req) begin
                  bus.pc_we     = 1'b0;
                  bus.if_id_flush = 1'b1;
                  drain_cnt_nxt = '0;
                  state_nxt     = DRAIN;
               end
            end
            STALL: begin
               state_nxt = RUN;
               if (bus.ex_branch_taken) begin
                  bus.pc_src_branch = 1'b1;
                  bus.if_id_flush   = 1'b1;
                  bus.id_ex_flush   = 1'b1;
                  flush_inc         = 1'b1;
               end
            end
            DRAIN: begin
               bus.pc_we       = 1'b0;
               bus.if_id_flush = 1'b1;
               // A branch already in EX still redirects the PC; the drain keeps counting.
               if (bus.ex_branch_taken) begin
                  bus.pc_we         = 1'b1;
                  bus.pc_src_branch = 1'b1;
                  bus.id_ex_flush   = 1'b1;
                  flush_inc         = 1'b1;
               end
               if (drain_cnt == DRAIN_LAST) state_nxt = HALTED;
               else drain_cnt_nxt = drain_cnt + DW'(1);
            end
            HALTED: begin
               bus.pc_we       = 1'b0;
               bus.if_id_flush = 1'b1;
               if (!bus.halt_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
         endcase
      end

      // During reset the pipeline is held with bubbles in both front-end latches.
      if (!reset) begin
         bus.pc_we         = 1'b0;
         bus.if_id_we      = 1'b0;
         bus.if_id_flush   = 1'b1;
         bus.id_ex_flush   = 1'b1;
         bus.pc_src_branch = 1'b0;
         bus.pipe_freeze   = 1'b0;
         bus.halt_ack      = 1'b0;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, number of bubble cycles needed to empty ID/EX/DM/WB before halt is acknowledged.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source register addresses of the instruction in ID.
- id_rs_used, id_rt_used  in  1 each  ID instruction actually reads rs / rt.
- id_ex_mem_read  in  1  instruction in ID/EX is a load.
- id_ex_rd  in  5  destination of the instruction in ID/EX.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- dm_ready  in  1  data memory can complete this cycle; 0 freezes the pipeline.
- halt_req  in  1  level request to drain and halt fetch.
- pc_we  out  1  PC register write enable.
- pc_src_branch  out  1  PC mux selects branch target.
- if_id_we  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID loads a bubble (NOP).
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits 0).
- pipe_freeze  out  1  EX/DM and DM/WB hold their contents.
- halt_ack  out  1  pipeline empty and halted.
- stall_cnt  out  16  load-use bubbles inserted, saturating.
- flush_cnt  out  16  branch flushes performed, saturating.

Function
REQ-003 SHALL implement FSM states RUN, STALL, DRAIN, HALTED, plus a drain counter of width ceil(log2(DRAIN_CYCLES)) bits.
REQ-004 SHALL drive all control outputs combinationally from the current state and current inputs, so the response to a hazard occurs in the cycle the hazard is visible.
REQ-005 SHALL compute load_use = id_ex_mem_read & (id_ex_rd!=0) & ((id_rs_used & id_rs==id_ex_rd) | (id_rt_used & id_rt==id_ex_rd)); register 0 never causes a hazard.
REQ-006 Default outputs, when no rule below applies: pc_we=1, if_id_we=1, flushes=0, pc_src_branch=0, pipe_freeze=0, halt_ack=0.
REQ-007 Highest priority, any state, dm_ready=0: pc_we=0, if_id_we=0, pc_src_branch=0, both flushes=0, pipe_freeze=1, halt_ack unchanged from the state rule; FSM, drain counter and counters hold.
REQ-008 RUN with ex_branch_taken=1: pc_we=1, pc_src_branch=1, if_id_flush=1, id_ex_flush=1, flush_cnt+1, next RUN; any load_use or halt_req in the same cycle is ignored.
REQ-009 RUN with load_use=1 and no branch: pc_we=0, if_id_we=0, id_ex_flush=1, stall_cnt+1, next STALL (exactly one bubble).
REQ-010 RUN with halt_req=1 and no branch or load_use: pc_we=0, if_id_flush=1, drain counter cleared, next DRAIN.
REQ-011 STALL: default outputs with load_use ignored; next RUN. ex_branch_taken is handled as in REQ-008, with next state RUN.
REQ-012 DRAIN: pc_we=0, if_id_flush=1, drain counter+1 per unfrozen cycle. On count DRAIN_CYCLES-1, next HALTED.
REQ-013 DRAIN with ex_branch_taken=1: additionally pc_we=1, pc_src_branch=1, id_ex_flush=1, flush_cnt+1; drain continues uninterrupted.
REQ-014 halt_req is sampled only in RUN; deassertion during DRAIN does not abort the drain.
REQ-015 HALTED: halt_ack=1, pc_we=0, if_id_flush=1. When halt_req=0, next RUN; halt_ack falls at that edge.
REQ-016 Counters saturate at 16'hFFFF and never wrap.

Reset
REQ-017 While reset=0: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, pc_we=0, if_id_we=0, if_id_flush=1, id_ex_flush=1, pc_src_branch=0, pipe_freeze=0, halt_ack=0, independent of clk.
REQ-018 Reset asserted mid-DRAIN or in HALTED SHALL abandon the sequence; after release the block is in RUN with default outputs.

Verification
REQ-019 Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs=5, id_rs_used=1 -> pc_we=0, if_id_we=0, id_ex_flush=1 for exactly one cycle, then defaults; stall_cnt=1.
REQ-020 Register 0: same stimulus as REQ-019 with id_ex_rd=0 and id_rs=0 -> no stall; stall_cnt stays 0.
REQ-021 Branch plus load_use in the same RUN cycle -> pc_src_branch=1, both flushes=1, no stall; flush_cnt=1, stall_cnt=0.
REQ-022 Freeze: dm_ready=0 for 3 cycles during STALL -> pipe_freeze=1, all enables 0, state stays STALL; after dm_ready=1 it resumes from STALL.
REQ-023 Halt: halt_req=1 in RUN -> 4 DRAIN cycles with pc_we=0, then halt_ack=1; halt_req=0 -> next cycle RUN, halt_ack=0; reset mid-drain -> RUN and counters 0.
REQ-024 Saturation: preload 65535 load-use stalls -> stall_cnt=16'hFFFF and remains 16'hFFFF after one more stall.
